matrix_mul_t_seq: RTL and testbench

//  Sequential transposed matrix-vector multiply: VO = W^T * H (downward/backward pass of the RBM, hidden -> visible).

---
 rtl/matrix_mul_t_seq.sv | 140 ++++++++++++++
 tb/tb_matrix_mul_t_seq.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/matrix_mul_t_seq.sv
// Sequential transposed matrix-vector multiply VO = W^T * H using one MAC per cycle.
// Define MATMUL_T_SATURATE_EN for saturating accumulation; default build wraps modulo 2^bitlength.
module matrix_mul_t_seq #(
  parameter int bitlength = 8,
  parameter int M1_D1     = 3,
  parameter int M1_D2     = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [M1_D1*M1_D2*bitlength-1:0]   WI,
  input  logic [M1_D1*bitlength-1:0]         HI,
  input  logic                               start,
  output logic                               busy,
  output logic                               done,
  output logic [M1_D2*bitlength-1:0]         VO
);

  localparam int RW = $clog2(M1_D1 + 1);
  localparam int CW = $clog2(M1_D2 + 1);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_DONE} state_e;

  state_e                             state_q, state_d;
  logic [RW-1:0]                      r_q, r_d;
  logic [CW-1:0]                      c_q, c_d;
  logic [M1_D1*M1_D2*bitlength-1:0]   w_q, w_d;
  logic [M1_D1*bitlength-1:0]         h_q, h_d;
  logic [M1_D2*bitlength-1:0]         acc_q, acc_d;
  logic [M1_D2*bitlength-1:0]         vo_q, vo_d;

  logic [bitlength-1:0] w_sel, h_sel, acc_sel, acc_upd;
  logic                 last_mac;

  // Operand and accumulator selection by the 1-based r,c counters.
  always_comb begin
    w_sel   = '0;
    h_sel   = '0;
    acc_sel = '0;
    for (int i = 0; i < M1_D1; i++) begin
      if (r_q == RW'(i + 1)) begin
        h_sel = h_q[i*bitlength +: bitlength];
        for (int j = 0; j < M1_D2; j++) begin
          if (c_q == CW'(j + 1)) w_sel = w_q[(i*M1_D2 + j)*bitlength +: bitlength];
        end
      end
    end
    for (int j = 0; j < M1_D2; j++) begin
      if (c_q == CW'(j + 1)) acc_sel = acc_q[j*bitlength +: bitlength];
    end
  end

`ifdef MATMUL_T_SATURATE_EN
  logic [2*bitlength-1:0] prod;
  logic [2*bitlength:0]   sum;

  always_comb begin
    prod    = {{bitlength{1'b0}}, w_sel} * {{bitlength{1'b0}}, h_sel};
    sum     = {1'b0, prod} + {{(bitlength+1){1'b0}}, acc_sel};
    // Any bit at or above bitlength means the true sum exceeds the max value.
    acc_upd = (|sum[2*bitlength:bitlength]) ? {bitlength{1'b1}} : sum[bitlength-1:0];
  end
`else
  logic [bitlength-1:0] prod;

  always_comb begin
    prod    = w_sel * h_sel;
    acc_upd = acc_sel + prod;
  end
`endif

  assign last_mac = (r_q == RW'(M1_D1)) && (c_q == CW'(M1_D2));

  // NOTE: every variable gets its default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    c_d     = c_q;
    w_d     = w_q;
    h_d     = h_q;
    acc_d   = acc_q;
    vo_d    = vo_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_MAC;
          w_d     = WI;
          h_d     = HI;
          acc_d   = '0;
          r_d     = RW'(1);
          c_d     = CW'(1);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MAC: begin
        for (int j = 0; j < M1_D2; j++) begin
          if (c_q == CW'(j + 1)) acc_d[j*bitlength +: bitlength] = acc_upd;
        end
        if (last_mac) begin
          vo_d    = acc_d;
          state_d = S_DONE;
          r_d     = RW'(1);
          c_d     = CW'(1);
        end else if (c_q == CW'(M1_D2)) begin
          c_d = CW'(1);
          r_d = r_q + 1'b1;
        end else begin
          c_d = c_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      r_q     <= RW'(1);
      c_q     <= CW'(1);
      w_q     <= '0;
      h_q     <= '0;
      acc_q   <= '0;
      vo_q    <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      c_q     <= c_d;
      w_q     <= w_d;
      h_q     <= h_d;
      acc_q   <= acc_d;
      vo_q    <= vo_d;
    end
  end

  assign busy = (state_q == S_MAC);
  assign done = (state_q == S_DONE);
  assign VO   = vo_q;

endmodule

// File: tb/tb_matrix_mul_t_seq.sv
// Self-checking bench for matrix_mul_t_seq: directed vectors with hand-computed results plus
// randomized runs checked against a small behavioural model.
module tb_matrix_mul_t_seq;

  localparam int BL = 8;
  localparam int D1 = 3;
  localparam int D2 = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [D1*D2*BL-1:0]   WI;
  logic [D1*BL-1:0]      HI;
  logic                  start;
  logic                  busy;
  logic                  done;
  logic [D2*BL-1:0]      VO;

  int n_checks = 0;
  int n_fail   = 0;

  matrix_mul_t_seq #(.bitlength(BL), .M1_D1(D1), .M1_D2(D2)) dut (
    .clk   (clk),
    .rst   (rst),
    .WI    (WI),
    .HI    (HI),
    .start (start),
    .busy  (busy),
    .done  (done),
    .VO    (VO)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [D1*D2*BL-1:0] fill_w(input logic [BL-1:0] v);
    logic [D1*D2*BL-1:0] w;
    for (int k = 0; k < D1*D2; k++) w[k*BL +: BL] = v;
    return w;
  endfunction

  function automatic logic [D2*BL-1:0] model(input logic [D1*D2*BL-1:0] w, input logic [D1*BL-1:0] h);
    logic [D2*BL-1:0] vo;
    int acc;
    for (int c = 0; c < D2; c++) begin
      acc = 0;
      for (int r = 0; r < D1; r++) begin
`ifdef MATMUL_T_SATURATE_EN
        acc = acc + int'(w[(r*D2 + c)*BL +: BL]) * int'(h[r*BL +: BL]);
        if (acc > 255) acc = 255;
`else
        acc = (acc + int'(w[(r*D2 + c)*BL +: BL]) * int'(h[r*BL +: BL])) % 256;
`endif
      end
      vo[c*BL +: BL] = acc[BL-1:0];
    end
    return vo;
  endfunction

  // Drives one start pulse; returns at the negedge after the accepting edge (first MAC cycle).
  task automatic start_run(input logic [D1*D2*BL-1:0] w, input logic [D1*BL-1:0] h);
    @(negedge clk);
    WI    = w;
    HI    = h;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts negedges from the first MAC cycle (lat=1) until done is seen, bounded.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat      = 1;
    busy_cnt = 0;
    while (!done && lat < 40) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  logic [D1*D2*BL-1:0] w_ident;
  logic [D1*BL-1:0]    h_123, h_579;
  logic [D2*BL-1:0]    exp_sat;
  int lat, bcnt;

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    WI    = '0;
    HI    = '0;
    w_ident = '0;
    for (int r = 0; r < D1; r++) w_ident[(r*D2 + r)*BL +: BL] = 8'd1;
    h_123 = {8'd3, 8'd2, 8'd1};
    h_579 = {8'd9, 8'd7, 8'd5};

    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_vo",   64'(VO),   64'd0);
    rst = 1'b0;

    // Test 1: W all ones, H=[1,2,3]
    start_run(fill_w(8'd1), h_123);
    wait_done(lat, bcnt);
    check("t1_latency", 64'(lat),  64'd13);
    check("t1_busy_cycles", 64'(bcnt), 64'd12);
    check("t1_vo", 64'(VO), 64'h06060606);
    @(negedge clk);
    check("t1_done_pulse", 64'(done), 64'd0);
    check("t1_idle_busy",  64'(busy), 64'd0);
    check("t1_vo_hold",    64'(VO),   64'h06060606);

    // Test 2: identity-like W, H changed mid-run must not matter
    start_run(w_ident, h_579);
    repeat (3) @(negedge clk);
    HI = 24'hFFFFFF;
    WI = fill_w(8'd77);
    wait_done(lat, bcnt);
    check("t2_latency", 64'(lat), 64'd10);
    check("t2_vo", 64'(VO), 64'h00090705);

    // Test 3: overflow behaviour
`ifdef MATMUL_T_SATURATE_EN
    exp_sat = 32'hFFFFFFFF;
`else
    exp_sat = 32'h90909090;
`endif
    start_run(fill_w(8'd200), {8'd0, 8'd0, 8'd2});
    wait_done(lat, bcnt);
    check("t3_latency", 64'(lat), 64'd13);
    check("t3_vo", 64'(VO), 64'(exp_sat));

    // Test 4: start held high; restart only in DONE, new operands latched there
    @(negedge clk);
    WI    = fill_w(8'd1);
    HI    = h_123;
    start = 1'b1;
    @(negedge clk);
    wait_done(lat, bcnt);
    check("t4_first_latency", 64'(lat), 64'd13);
    check("t4_first_busy",    64'(bcnt), 64'd12);
    check("t4_first_vo",      64'(VO), 64'h06060606);
    WI = w_ident;
    HI = h_579;
    @(negedge clk);
    check("t4_b2b_busy", 64'(busy), 64'd1);
    wait_done(lat, bcnt);
    start = 1'b0;
    check("t4_second_latency", 64'(lat), 64'd13);
    check("t4_second_vo", 64'(VO), 64'h00090705);
    @(negedge clk);
    check("t4_end_busy", 64'(busy), 64'd0);
    check("t4_end_done", 64'(done), 64'd0);

    // Test 5: reset during the 5th MAC cycle
    start_run(fill_w(8'd3), h_579);
    repeat (4) @(negedge clk);
    check("t5_busy_before_rst", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_rst_busy", 64'(busy), 64'd0);
    check("t5_rst_done", 64'(done), 64'd0);
    check("t5_rst_vo",   64'(VO),   64'd0);
    start_run(fill_w(8'd1), h_123);
    wait_done(lat, bcnt);
    check("t5_latency", 64'(lat), 64'd13);
    check("t5_vo", 64'(VO), 64'h06060606);

    // Test 6: randomized operands against the model
    for (int n = 0; n < 200; n++) begin
      logic [D1*D2*BL-1:0] rw;
      logic [D1*BL-1:0]    rh;
      for (int k = 0; k < D1*D2; k++) rw[k*BL +: BL] = 8'($urandom_range(0, 255));
      for (int k = 0; k < D1; k++)    rh[k*BL +: BL] = 8'($urandom_range(0, 255));
      start_run(rw, rh);
      wait_done(lat, bcnt);
      check("t6_rand_vo", 64'(VO), 64'(model(rw, rh)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

●
